// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 208;
  localparam int unsigned UART_BUF_DEPTH       = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  // Requested lengths beyond the buffer size send the whole buffer once.
  function automatic logic [9:0] clamp_len(input logic [9:0] len);
    return (len > 10'(UART_BUF_DEPTH)) ? 10'(UART_BUF_DEPTH) : len;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Host control and Tx buffer read port of the UART transmit engine.
interface uart_tx_engine_if #(
  parameter int unsigned ADDR_W = 9
) ();

  logic              tx_start;
  logic [9:0]        tx_len;
  logic              tx_abort;
  logic [ADDR_W-1:0] tx_fifo_ra;
  logic              tx_fifo_ren;
  logic [7:0]        tx_fifo_rd;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output tx_start, tx_len, tx_abort, tx_fifo_rd,
    input  tx_fifo_ra, tx_fifo_ren, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_len, tx_abort, tx_fifo_rd,
    output tx_fifo_ra, tx_fifo_ren, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_tx_shift.sv
// Serializes one byte as start, 8 data bits LSB first and stop, on a registered tx pin.
module uart_tx_shift
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       abort,
  input  logic [7:0] din,
  output logic       tx,
  output logic       bit_done,
  output logic       last_data_bit,
  output logic       frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         phase;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        sh;

  assign bit_done      = (phase != S_IDLE) && (baud == BAUD_MAX);
  assign last_data_bit = (phase == S_DATA) && (bit_idx == 3'd7);
  assign frame_done    = bit_done && (phase == S_STOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else if (abort) begin
      phase <= S_IDLE;
      baud  <= '0;
      tx    <= 1'b1;
    end else if (load) begin
      phase   <= S_START;
      baud    <= '0;
      bit_idx <= '0;
      sh      <= din;
      tx      <= 1'b0;
    end else if (phase != S_IDLE) begin
      if (!bit_done) begin
        baud <= baud + 1'b1;
      end else begin
        baud <= '0;
        // The next bit is presented on tx at the edge that ends the current one.
        case (phase)
          S_START: begin
            phase   <= S_DATA;
            bit_idx <= '0;
            tx      <= sh[0];
            sh      <= {1'b0, sh[7:1]};
          end
          S_DATA: begin
            if (bit_idx == 3'd7) begin
              phase <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= sh[0];
              sh      <= {1'b0, sh[7:1]};
            end
          end
          default: begin
            phase <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: fetches tx_len bytes from the Tx buffer and sends them as 8N1 frames.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned ADDR_W       = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_engine_if.slave bus,
  output logic            tx
);

  tx_state_t         state;
  logic [9:0]        len_q;
  logic [9:0]        bytes_sent;
  logic [ADDR_W-1:0] ra_q;
  logic              ren_q;
  logic              busy_q;
  logic              done_q;
  logic              load;
  logic              accept;
  logic              bit_done;
  logic              last_data_bit;
  logic              frame_done;

  // done_q marks the final busy cycle of a transfer; a start there is still "while busy".
  assign accept = bus.tx_start && !bus.tx_abort && (bus.tx_len != '0) && !done_q;
  assign load   = (state == S_LATCH);

  assign bus.tx_fifo_ra  = ra_q;
  assign bus.tx_fifo_ren = ren_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;

  uart_tx_shift #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_shift (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .abort        (bus.tx_abort),
    .din          (bus.tx_fifo_rd),
    .tx           (tx),
    .bit_done     (bit_done),
    .last_data_bit(last_data_bit),
    .frame_done   (frame_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      bytes_sent <= '0;
      ra_q       <= '0;
      ren_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ren_q  <= 1'b0;
      done_q <= 1'b0;
      if (state != S_IDLE && bus.tx_abort) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (done_q) begin
              busy_q <= 1'b0;
            end else if (accept) begin
              len_q      <= clamp_len(bus.tx_len);
              bytes_sent <= '0;
              ra_q       <= '0;
              busy_q     <= 1'b1;
              ren_q      <= 1'b1;
              state      <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LATCH;
          S_LATCH: state <= S_START;
          S_START: if (bit_done) state <= S_DATA;
          S_DATA:  if (bit_done && last_data_bit) state <= S_STOP;
          S_STOP: begin
            if (frame_done) begin
              if (bytes_sent + 10'd1 == len_q) begin
                done_q <= 1'b1;
                state  <= S_IDLE;
              end else begin
                bytes_sent <= bytes_sent + 10'd1;
                ra_q       <= ra_q + 1'b1;
                ren_q      <= 1'b1;
                state      <= S_FETCH;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
